// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce; emits enter/clear strobes and holds the digit.
// Latency: 2-flop sync + DEBOUNCE_TICKS sample ticks, strobe one cycle after EMIT; no backpressure, strobes are fire-and-forget.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] digit,
    output logic       enter,
    output logic       clear,
    output logic       busy
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_EMIT     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      rs_meta_q, rs_q;
    logic [DW-1:0]   div_q;
    logic [3:0]      col_q, col_d;
    logic [1:0]      row_q, row_d;
    logic [CW-1:0]   stable_q, stable_d;
    logic [CW-1:0]   rel_q, rel_d;
    logic [3:0]      digit_q, digit_d;
    logic            enter_q, enter_d;
    logic            clear_q, clear_d;

    logic            tick;
    logic [3:0]      col_rot;
    logic [1:0]      low_row;
    logic [1:0]      col_idx;
    logic [3:0]      key_code;
    logic [CW:0]     stable_inc;
    logic [CW:0]     rel_inc;

    // row_in is asynchronous to clk; idle (all released) reads as 4'hF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_meta_q <= 4'hF;
            rs_q      <= 4'hF;
        end else begin
            rs_meta_q <= row_in;
            rs_q      <= rs_meta_q;
        end
    end

    assign tick = (div_q == DW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign col_rot    = {col_q[2:0], col_q[3]};
    assign stable_inc = {1'b0, stable_q} + 1'b1;
    assign rel_inc    = {1'b0, rel_q} + 1'b1;

    always_comb begin
        low_row = 2'd3;
        if (!rs_q[0])      low_row = 2'd0;
        else if (!rs_q[1]) low_row = 2'd1;
        else if (!rs_q[2]) low_row = 2'd2;
    end

    always_comb begin
        col_idx = 2'd3;
        if (!col_q[0])      col_idx = 2'd0;
        else if (!col_q[1]) col_idx = 2'd1;
        else if (!col_q[2]) col_idx = 2'd2;
    end

    always_comb begin
        key_code = 4'd0;
        case ({row_q, col_idx})
            4'b00_00: key_code = 4'd1;
            4'b00_01: key_code = 4'd2;
            4'b00_10: key_code = 4'd3;
            4'b00_11: key_code = 4'd10;
            4'b01_00: key_code = 4'd4;
            4'b01_01: key_code = 4'd5;
            4'b01_10: key_code = 4'd6;
            4'b01_11: key_code = 4'd11;
            4'b10_00: key_code = 4'd7;
            4'b10_01: key_code = 4'd8;
            4'b10_10: key_code = 4'd9;
            4'b10_11: key_code = 4'd12;
            4'b11_00: key_code = 4'd14;
            4'b11_01: key_code = 4'd0;
            4'b11_10: key_code = 4'd15;
            default:  key_code = 4'd13;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        stable_d = stable_q;
        rel_d    = rel_q;
        digit_d  = digit_q;
        enter_d  = 1'b0;
        clear_d  = 1'b0;
        case (state_q)
            S_SCAN: begin
                if (tick) begin
                    if (rs_q == 4'hF) begin
                        col_d = col_rot;
                    end else begin
                        row_d    = low_row;
                        stable_d = CW'(1);
                        state_d  = S_DEBOUNCE;
                    end
                end
            end
            S_DEBOUNCE: begin
                // Only the latched row is watched; other rows going low are ignored.
                if (tick) begin
                    if (!rs_q[row_q]) begin
                        stable_d = stable_inc[CW-1:0];
                        if (stable_inc >= (CW+1)'(DEBOUNCE_TICKS)) begin
                            state_d = S_EMIT;
                        end
                    end else begin
                        state_d = S_SCAN;
                        col_d   = col_rot;
                    end
                end
            end
            S_EMIT: begin
                digit_d = key_code;
                enter_d = (key_code <= 4'd9);
                clear_d = (key_code == 4'd14);
                rel_d   = '0;
                state_d = S_RELEASE;
            end
            default: begin
                if (tick) begin
                    if (rs_q == 4'hF) begin
                        rel_d = rel_inc[CW-1:0];
                        if (rel_inc >= (CW+1)'(DEBOUNCE_TICKS)) begin
                            state_d = S_SCAN;
                            col_d   = col_rot;
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_SCAN;
            col_q    <= 4'b1110;
            row_q    <= 2'd0;
            stable_q <= '0;
            rel_q    <= '0;
            digit_q  <= 4'd0;
            enter_q  <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            stable_q <= stable_d;
            rel_q    <= rel_d;
            digit_q  <= digit_d;
            enter_q  <= enter_d;
            clear_q  <= clear_d;
        end
    end

    assign col_out = col_q;
    assign digit   = digit_q;
    assign enter   = enter_q;
    assign clear   = clear_q;
    assign busy    = (state_q != S_SCAN);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural keypad matrix drives row_in from col_out.
module tb_keypad_scanner;

    logic       clk;
    logic       rst_n;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] digit;
    logic       enter;
    logic       clear;
    logic       busy;

    logic [15:0] keys;
    int          total;
    int          bad;
    int          enter_cnt;
    int          clear_cnt;
    logic [3:0]  enter_dig [0:255];
    logic [3:0]  clear_dig;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_TICKS (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .row_in  (row_in),
        .col_out (col_out),
        .digit   (digit),
        .enter   (enter),
        .clear   (clear),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key index = row*4 + col; a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    initial begin
        enter_cnt = 0;
        clear_cnt = 0;
        clear_dig = 4'd0;
    end

    always @(negedge clk) begin
        if (enter) begin
            enter_dig[enter_cnt[7:0]] = digit;
            enter_cnt = enter_cnt + 1;
        end
        if (clear) begin
            clear_dig = digit;
            clear_cnt = clear_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (!busy) break;
            cyc(1);
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_busy(input string tag, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (busy) break;
            cyc(1);
        end
        check(tag, {31'd0, busy}, 32'd1);
    endtask

    int base_e;
    int base_c;

    initial begin
        total = 0;
        bad   = 0;
        keys  = 16'h0;
        rst_n = 1'b0;
        cyc(3);
        check("rst col_out", {28'd0, col_out}, 32'hE);
        check("rst digit",   {28'd0, digit},   32'd0);
        check("rst enter",   {31'd0, enter},   32'd0);
        check("rst clear",   {31'd0, clear},   32'd0);
        check("rst busy",    {31'd0, busy},    32'd0);
        rst_n = 1'b1;
        cyc(10);

        // '7' held 200 cycles then released
        base_e = enter_cnt; base_c = clear_cnt;
        keys = 16'h1 << 8;
        cyc(200);
        check("k7 busy held", {31'd0, busy}, 32'd1);
        keys = 16'h0;
        cyc(2);
        check("k7 busy after release", {31'd0, busy}, 32'd1);
        wait_idle("k7 idle", 40);
        check("k7 enter count", enter_cnt - base_e, 32'd1);
        check("k7 pulse digit", {28'd0, enter_dig[base_e[7:0]]}, 32'd7);
        check("k7 clear count", clear_cnt - base_c, 32'd0);
        check("k7 digit held", {28'd0, digit}, 32'd7);

        // '0' bouncing one tick low / one tick high, three times
        base_e = enter_cnt;
        for (int i = 0; i < 3; i++) begin
            keys = 16'h1 << 13;
            cyc(4);
            keys = 16'h0;
            cyc(4);
        end
        check("k0 bounce no enter", enter_cnt - base_e, 32'd0);
        keys = 16'h1 << 13;
        cyc(100);
        keys = 16'h0;
        wait_idle("k0 idle", 40);
        check("k0 enter count", enter_cnt - base_e, 32'd1);
        check("k0 pulse digit", {28'd0, enter_dig[base_e[7:0]]}, 32'd0);

        // '*' then 'A'
        base_e = enter_cnt; base_c = clear_cnt;
        keys = 16'h1 << 12;
        cyc(100);
        keys = 16'h0;
        wait_idle("star idle", 40);
        check("star clear count", clear_cnt - base_c, 32'd1);
        check("star clear digit", {28'd0, clear_dig}, 32'd14);
        check("star enter count", enter_cnt - base_e, 32'd0);
        check("star digit", {28'd0, digit}, 32'd14);
        keys = 16'h1 << 3;
        cyc(100);
        keys = 16'h0;
        wait_idle("A idle", 40);
        check("A digit", {28'd0, digit}, 32'd10);
        check("A enter count", enter_cnt - base_e, 32'd0);
        check("A clear count", clear_cnt - base_c, 32'd1);

        // '5' and '8' together in column 1: row 1 wins
        base_e = enter_cnt;
        keys = (16'h1 << 5) | (16'h1 << 9);
        cyc(100);
        keys = 16'h0;
        wait_idle("k5 idle", 40);
        check("k5 enter count", enter_cnt - base_e, 32'd1);
        check("k5 pulse digit", {28'd0, enter_dig[base_e[7:0]]}, 32'd5);

        // 9,9,7,9 with full release between keys
        base_e = enter_cnt;
        for (int i = 0; i < 4; i++) begin
            keys = (i == 2) ? (16'h1 << 8) : (16'h1 << 10);
            cyc(1000);
            keys = 16'h0;
            wait_idle("seq idle", 40);
        end
        check("seq enter count", enter_cnt - base_e, 32'd4);
        check("seq digit 0", {28'd0, enter_dig[8'(base_e + 0)]}, 32'd9);
        check("seq digit 1", {28'd0, enter_dig[8'(base_e + 1)]}, 32'd9);
        check("seq digit 2", {28'd0, enter_dig[8'(base_e + 2)]}, 32'd7);
        check("seq digit 3", {28'd0, enter_dig[8'(base_e + 3)]}, 32'd9);

        // reset asserted while '3' is being debounced
        base_e = enter_cnt;
        keys = 16'h1 << 2;
        wait_busy("k3 debounce start", 60);
        cyc(1);
        rst_n = 1'b0;
        #1;
        check("k3 rst digit",   {28'd0, digit},   32'd0);
        check("k3 rst col_out", {28'd0, col_out}, 32'hE);
        check("k3 rst busy",    {31'd0, busy},    32'd0);
        check("k3 rst enter",   {31'd0, enter},   32'd0);
        cyc(5);
        rst_n = 1'b1;
        cyc(12);
        check("k3 no early enter", enter_cnt - base_e, 32'd0);
        cyc(100);
        check("k3 enter count", enter_cnt - base_e, 32'd1);
        check("k3 pulse digit", {28'd0, enter_dig[base_e[7:0]]}, 32'd3);
        check("k3 digit", {28'd0, digit}, 32'd3);
        keys = 16'h0;
        wait_idle("k3 idle", 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
